// File: rtl/sfu_exp_lut_interp.sv
// sfu_exp_lut_interp: drives the dual-port exp LUT and linearly interpolates between adjacent entries.
module sfu_exp_lut_interp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 20,
    parameter int FRAC_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] in_x,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_y,
    output logic [ADDR_WIDTH-1:0]          lut_addr_a,
    output logic [ADDR_WIDTH-1:0]          lut_addr_b,
    output logic                           lut_en,
    input  logic [DATA_WIDTH-1:0]          lut_q_a,
    input  logic [DATA_WIDTH-1:0]          lut_q_b
);
    localparam int PW = DATA_WIDTH + FRAC_WIDTH + 1;
    logic                    v1, v2, adv1, adv2, accept;
    logic [FRAC_WIDTH-1:0]   frac1;
    logic [ADDR_WIDTH-1:0]   idx;
    logic signed [DATA_WIDTH:0] diff;
    logic signed [PW-1:0]    prod, rnd;
    logic [DATA_WIDTH-1:0]   delta;
    assign idx        = in_x[ADDR_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
    assign adv2       = !v2 || out_ready;
    assign adv1       = !v1 || adv2;
    assign in_ready   = adv1 && rst_n;
    assign accept     = in_valid && in_ready;
    assign out_valid  = v2;
    assign lut_en     = accept;
    assign lut_addr_a = idx;
    // top segment clamps onto itself instead of wrapping to entry 0
    assign lut_addr_b = (idx == {ADDR_WIDTH{1'b1}}) ? idx : idx + ADDR_WIDTH'(1);
    assign diff       = $signed({1'b0, lut_q_b}) - $signed({1'b0, lut_q_a});
    assign prod       = PW'(diff) * PW'($signed({1'b0, frac1}));
    assign rnd        = prod + PW'(1 << (FRAC_WIDTH - 1));
    assign delta      = DATA_WIDTH'(rnd >>> FRAC_WIDTH);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            frac1 <= '0;
            out_y <= '0;
        end else begin
            if (accept) begin
                v1    <= 1'b1;
                frac1 <= in_x[FRAC_WIDTH-1:0];
            end else if (adv2) begin
                v1 <= 1'b0;
            end
            if (v1 && adv2) begin
                v2    <= 1'b1;
                out_y <= lut_q_a + delta;
            end else if (v2 && out_ready) begin
                v2 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sfu_exp_lut_interp.sv
// tb_sfu_exp_lut_interp: directed vectors with a queue scoreboard and an independent output monitor.
module tb_sfu_exp_lut_interp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_x = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_y;
    logic [4:0]  lut_addr_a, lut_addr_b;
    logic        lut_en;
    logic [19:0] lut_q_a = '0, lut_q_b = '0;
    logic [19:0] lut_mem [32];
    logic [19:0] exp_q [$];
    logic [19:0] stream_exp [6];
    logic [19:0] prev_y = '0;
    logic        prev_stall = 1'b0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sfu_exp_lut_interp dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .lut_addr_a(lut_addr_a), .lut_addr_b(lut_addr_b), .lut_en(lut_en),
        .lut_q_a(lut_q_a), .lut_q_b(lut_q_b)
    );

    always @(posedge clk) if (lut_en) begin
        lut_q_a <= lut_mem[lut_addr_a];
        lut_q_b <= lut_mem[lut_addr_b];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic send(input logic [12:0] x, input logic [19:0] e, input bit push);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_x = x;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready) begin
            if (push) exp_q.push_back(e);
        end else chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_y", out_y, prev_y);
            end
            chk("lut_en", lut_en, in_valid && in_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", out_y, 20'hFFFFF);
                else chk("out_y", out_y, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_y = out_y;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) lut_mem[i] = 20'h00400 * i;
        lut_mem[0]  = 20'h00267; lut_mem[1]  = 20'h004AD; lut_mem[2] = 20'h006D2;
        lut_mem[3]  = 20'h008D7; lut_mem[4]  = 20'h00ABA; lut_mem[5] = 20'h00C7B;
        lut_mem[16] = 20'h0160C; lut_mem[17] = 20'h015F2; lut_mem[31] = 20'h00004;
        stream_exp = '{20'h0267, 20'h04AD, 20'h06D2, 20'h08D7, 20'h0ABA, 20'h0C7B};
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_y", out_y, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_lut_en", lut_en, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(13'h0000, 20'h00267, 1);
        @(negedge clk);
        #1 chk("lat_cycle1", out_valid, 0);
        @(negedge clk);
        #1 chk("lat_cycle2", out_valid, 1);
        drain();
        send(13'h0180, 20'h005C0, 1);
        send(13'h0240, 20'h00753, 1);
        send(13'h1040, 20'h01606, 1);
        drain();
        @(negedge clk);
        in_x = 13'h1FFF;
        #1;
        chk("clamp_addr_a", lut_addr_a, 31);
        chk("clamp_addr_b", lut_addr_b, 31);
        in_x = 13'h0500;
        #1 chk("addr_b_inc", lut_addr_b, 6);
        send(13'h1FFF, 20'h00004, 1);
        drain();
        fork
            for (int i = 0; i < 6; i++) send({i[4:0], 8'h00}, stream_exp[i], 1);
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        @(negedge clk);
        out_ready = 1'b0;
        send(13'h0200, 20'h0, 0);
        send(13'h0300, 20'h0, 0);
        @(negedge clk);
        #1 chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_x = 13'h0180;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_lut_en", lut_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_y", out_y, 0);
        chk("post_rst_in_ready", in_ready, 1);
        exp_q.push_back(20'h005C0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        chk("final_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
